// File: rtl/soc_decerr_slave.sv
// AXI4 default responder: accepts any unmatched request, drains write beats and
// answers DECERR on every read beat and write response; keeps a debug error log.
//
// state  | meaning
// W_IDLE | waiting for AW, aw_ready_o high
// W_DATA | draining W beats until w_last_i
// W_RESP | presenting B (DECERR) until b_ready_i
// R_IDLE | waiting for AR, ar_ready_o high
// R_DATA | returning len+1 DECERR beats
module soc_decerr_slave #(
  parameter int unsigned          IdWidth   = 5,
  parameter int unsigned          DataWidth = 64,
  parameter int unsigned          AddrWidth = 64,
  parameter logic [DataWidth-1:0] RespData  = 64'hBADC_AB1E_BADC_AB1E
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [IdWidth-1:0]     aw_id_i,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic [7:0]             aw_len_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  input  logic                   w_last_i,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  output logic [IdWidth-1:0]     b_id_o,
  output logic [1:0]             b_resp_o,
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  input  logic [IdWidth-1:0]     ar_id_i,
  input  logic [AddrWidth-1:0]   ar_addr_i,
  input  logic [7:0]             ar_len_i,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [IdWidth-1:0]     r_id_o,
  output logic [DataWidth-1:0]   r_data_o,
  output logic [1:0]             r_resp_o,
  output logic                   r_last_o,
  output logic [31:0]            err_cnt_o,
  output logic [AddrWidth-1:0]   last_err_addr_o
);

  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  w_state_e               w_state_q, w_state_d;
  r_state_e               r_state_q, r_state_d;
  logic [IdWidth-1:0]     b_id_q, b_id_d;
  logic [IdWidth-1:0]     r_id_q, r_id_d;
  logic [7:0]             r_len_q, r_len_d;
  logic [7:0]             r_cnt_q, r_cnt_d;
  logic [31:0]            err_cnt_q, err_cnt_d;
  logic [AddrWidth-1:0]   last_addr_q, last_addr_d;

  logic        aw_hs, ar_hs, r_last;
  logic [1:0]  err_inc;
  logic [32:0] err_sum;

  // Write payload and burst length carry no meaning for an error responder.
  logic unused_inputs;
  assign unused_inputs = ^{w_data_i, w_strb_i, aw_len_i};

  assign aw_hs  = aw_valid_i && (w_state_q == W_IDLE);
  assign ar_hs  = ar_valid_i && (r_state_q == R_IDLE);
  assign r_last = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);

  always_comb begin
    w_state_d = w_state_q;
    b_id_d    = b_id_q;
    unique case (w_state_q)
      W_IDLE: if (aw_valid_i) begin
        b_id_d    = aw_id_i;
        w_state_d = W_DATA;
      end
      W_DATA: if (w_valid_i && w_last_i) w_state_d = W_RESP;
      W_RESP: if (b_ready_i) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // The beat counter is never advanced on the last beat, so len=255 cannot wrap.
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    unique case (r_state_q)
      R_IDLE: if (ar_valid_i) begin
        r_id_d    = ar_id_i;
        r_len_d   = ar_len_i;
        r_cnt_d   = 8'd0;
        r_state_d = R_DATA;
      end
      R_DATA: if (r_ready_i) begin
        if (r_last) r_state_d = R_IDLE;
        else        r_cnt_d   = r_cnt_q + 8'd1;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    err_inc   = {1'b0, aw_hs} + {1'b0, ar_hs};
    err_sum   = {1'b0, err_cnt_q} + {31'd0, err_inc};
    err_cnt_d = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
    last_addr_d = last_addr_q;
    if (ar_hs)      last_addr_d = ar_addr_i;
    else if (aw_hs) last_addr_d = aw_addr_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      b_id_q      <= '0;
      r_id_q      <= '0;
      r_len_q     <= '0;
      r_cnt_q     <= '0;
      err_cnt_q   <= '0;
      last_addr_q <= '0;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      b_id_q      <= b_id_d;
      r_id_q      <= r_id_d;
      r_len_q     <= r_len_d;
      r_cnt_q     <= r_cnt_d;
      err_cnt_q   <= err_cnt_d;
      last_addr_q <= last_addr_d;
    end
  end

  assign aw_ready_o      = (w_state_q == W_IDLE);
  assign w_ready_o       = (w_state_q == W_DATA);
  assign b_valid_o       = (w_state_q == W_RESP);
  assign b_id_o          = b_id_q;
  assign b_resp_o        = RespDecErr;
  assign ar_ready_o      = (r_state_q == R_IDLE);
  assign r_valid_o       = (r_state_q == R_DATA);
  assign r_id_o          = r_id_q;
  assign r_data_o        = RespData;
  assign r_resp_o        = RespDecErr;
  assign r_last_o        = r_last;
  assign err_cnt_o       = err_cnt_q;
  assign last_err_addr_o = last_addr_q;

endmodule

// File: tb/tb_soc_decerr_slave.sv
// Directed bench for soc_decerr_slave: inputs driven and outputs sampled on the
// falling edge, expected values hand-derived.
module tb_soc_decerr_slave;

  localparam logic [63:0] RESP_DATA = 64'hBADC_AB1E_BADC_AB1E;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        aw_valid_i = 1'b0, aw_ready_o;
  logic [4:0]  aw_id_i = '0;
  logic [63:0] aw_addr_i = '0;
  logic [7:0]  aw_len_i = '0;
  logic        w_valid_i = 1'b0, w_ready_o, w_last_i = 1'b0;
  logic [63:0] w_data_i = '0;
  logic [7:0]  w_strb_i = '0;
  logic        b_valid_o, b_ready_i = 1'b1;
  logic [4:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        ar_valid_i = 1'b0, ar_ready_o;
  logic [4:0]  ar_id_i = '0;
  logic [63:0] ar_addr_i = '0;
  logic [7:0]  ar_len_i = '0;
  logic        r_valid_o, r_ready_i = 1'b1;
  logic [4:0]  r_id_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic [31:0] err_cnt_o;
  logic [63:0] last_err_addr_o;

  int checks = 0;
  int failures = 0;

  soc_decerr_slave dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
    .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
    .w_data_i(w_data_i), .w_strb_i(w_strb_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i),
    .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .err_cnt_o(err_cnt_o), .last_err_addr_o(last_err_addr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  // Expects beat 0 visible now with r_ready_i=1; checks n beats then the idle cycle.
  task automatic read_beats(input string tag, input logic [4:0] id, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_rvalid"}, r_valid_o, 1'b1);
      check({tag, "_rid"}, r_id_o, id);
      check({tag, "_rdata"}, r_data_o, RESP_DATA);
      check({tag, "_rresp"}, r_resp_o, 2'b11);
      check({tag, "_rlast"}, r_last_o, (i == n - 1));
      check({tag, "_arready_busy"}, ar_ready_o, 1'b0);
      tick();
    end
    check({tag, "_rvalid_end"}, r_valid_o, 1'b0);
    check({tag, "_arready_end"}, ar_ready_o, 1'b1);
  endtask

  task automatic issue_ar(input logic [63:0] addr, input logic [4:0] id, input logic [7:0] len);
    ar_valid_i = 1'b1; ar_addr_i = addr; ar_id_i = id; ar_len_i = len;
    check("ar_ready_before", ar_ready_o, 1'b1);
    tick();
    ar_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int beats;
    logic last_seen;
    repeat (2) tick();
    check("rst_aw_ready", aw_ready_o, 1'b1);
    check("rst_ar_ready", ar_ready_o, 1'b1);
    check("rst_w_ready", w_ready_o, 1'b0);
    check("rst_b_valid", b_valid_o, 1'b0);
    check("rst_r_valid", r_valid_o, 1'b0);
    check("rst_r_last", r_last_o, 1'b0);
    check("rst_b_id", b_id_o, 5'd0);
    check("rst_r_id", r_id_o, 5'd0);
    check("rst_err_cnt", err_cnt_o, 32'd0);
    check("rst_last_addr", last_err_addr_o, 64'd0);
    rst_ni = 1'b1;
    tick();

    // Basic read burst, len=3.
    issue_ar(64'h5000_0000, 5'h13, 8'd3);
    check("rd_err_cnt", err_cnt_o, 32'd1);
    check("rd_last_addr", last_err_addr_o, 64'h5000_0000);
    read_beats("rd4", 5'h13, 4);

    // Write with toggling w_valid and B backpressure.
    b_ready_i = 1'b0;
    aw_valid_i = 1'b1; aw_addr_i = 64'h6000_0000; aw_id_i = 5'd2; aw_len_i = 8'd1;
    tick();
    aw_valid_i = 1'b0;
    check("wr_aw_ready_busy", aw_ready_o, 1'b0);
    check("wr_w_ready", w_ready_o, 1'b1);
    check("wr_err_cnt", err_cnt_o, 32'd2);
    check("wr_last_addr", last_err_addr_o, 64'h6000_0000);
    w_valid_i = 1'b0; tick();
    w_valid_i = 1'b1; w_last_i = 1'b0; tick();
    w_valid_i = 1'b0; tick();
    check("wr_w_ready_mid", w_ready_o, 1'b1);
    check("wr_b_valid_early", b_valid_o, 1'b0);
    w_valid_i = 1'b1; w_last_i = 1'b1; tick();
    w_valid_i = 1'b0; w_last_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("wr_b_valid", b_valid_o, 1'b1);
      check("wr_b_id", b_id_o, 5'd2);
      check("wr_b_resp", b_resp_o, 2'b11);
      check("wr_w_ready_resp", w_ready_o, 1'b0);
      check("wr_aw_ready_resp", aw_ready_o, 1'b0);
      tick();
    end
    b_ready_i = 1'b1;
    check("wr_aw_ready_hs", aw_ready_o, 1'b0);
    tick();
    check("wr_b_valid_done", b_valid_o, 1'b0);
    check("wr_aw_ready_done", aw_ready_o, 1'b1);

    // Simultaneous AR and AW.
    aw_valid_i = 1'b1; aw_addr_i = 64'h7800_0000; aw_id_i = 5'h0A;
    issue_ar(64'h7000_0000, 5'h1F, 8'd0);
    aw_valid_i = 1'b0;
    check("both_err_cnt", err_cnt_o, 32'd4);
    check("both_last_addr", last_err_addr_o, 64'h7000_0000);
    check("both_w_ready", w_ready_o, 1'b1);
    w_valid_i = 1'b1; w_last_i = 1'b1;
    check("both_rlast", r_last_o, 1'b1);
    check("both_rid", r_id_o, 5'h1F);
    tick();
    w_valid_i = 1'b0; w_last_i = 1'b0;
    check("both_r_done", r_valid_o, 1'b0);
    check("both_b_valid", b_valid_o, 1'b1);
    check("both_b_id", b_id_o, 5'h0A);
    tick();
    check("both_b_done", b_valid_o, 1'b0);

    // len=255 with random r_ready backpressure.
    r_ready_i = 1'b0;
    issue_ar(64'h4000_0000, 5'h07, 8'd255);
    beats = 0;
    last_seen = 1'b0;
    for (int c = 0; c < 3000 && beats < 256; c++) begin
      if (r_valid_o) begin
        check("l255_rlast", r_last_o, (beats == 255));
        check("l255_rid", r_id_o, 5'h07);
        check("l255_rdata", r_data_o, RESP_DATA);
        r_ready_i = 1'($urandom_range(0, 1));
        if (r_ready_i) beats++;
      end else begin
        r_ready_i = 1'b0;
      end
      tick();
    end
    check("l255_beats", beats, 256);
    check("l255_idle", r_valid_o, 1'b0);
    r_ready_i = 1'b1;
    check("l255_err_cnt", err_cnt_o, 32'd5);

    // Saturation of the error counter.
    force dut.err_cnt_q = 32'hFFFF_FFFE;
    tick();
    release dut.err_cnt_q;
    aw_valid_i = 1'b1; aw_addr_i = 64'h1111_0000; aw_id_i = 5'd1;
    issue_ar(64'h2222_0000, 5'd3, 8'd0);
    aw_valid_i = 1'b0;
    check("sat_err_cnt", err_cnt_o, 32'hFFFF_FFFF);
    w_valid_i = 1'b1; w_last_i = 1'b1;
    tick();
    w_valid_i = 1'b0; w_last_i = 1'b0;
    tick();
    issue_ar(64'h3333_0000, 5'd4, 8'd0);
    check("sat_hold", err_cnt_o, 32'hFFFF_FFFF);
    check("sat_last_addr", last_err_addr_o, 64'h3333_0000);
    tick();

    // Reset during beat 2 of an 8-beat read.
    issue_ar(64'h5500_0000, 5'h09, 8'd7);
    tick(); tick();
    check("mid_rvalid_pre", r_valid_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_rvalid", r_valid_o, 1'b0);
    check("mid_rst_arready", ar_ready_o, 1'b1);
    check("mid_rst_err_cnt", err_cnt_o, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    issue_ar(64'h5A00_0000, 5'h04, 8'd2);
    check("post_rst_err_cnt", err_cnt_o, 32'd1);
    check("post_rst_last_addr", last_err_addr_o, 64'h5A00_0000);
    read_beats("post_rst", 5'h04, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
